// File: rtl/csr_unit_if.sv
// CSR access bus between the execute-stage decoder and csr_unit.
// master drives address/op/write/data; slave returns read data and illegal.
`timescale 1ns/1ps
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic            csr_write;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] rd_data;
  logic            illegal;

  modport master (
    output csr_addr, csr_op, csr_write, wr_data,
    input  rd_data, illegal
  );

  modport slave (
    input  csr_addr, csr_op, csr_write, wr_data,
    output rd_data, illegal
  );
endinterface

// File: rtl/csr_unit.sv
// FP CSRs (fflags/frm/fcsr), optional counters + mcountinhibit (CSR_COUNTERS_EN).
// Ports: i_clk, i_rst_n, bus (csr_unit_if.slave), i_fp_valid/flags, i_retire_cnt, o_frm.
`timescale 1ns/1ps
module csr_unit #(
  parameter int XLEN         = 32,
  parameter int NUM_FP_PORTS = 2,
  parameter int NUM_RETIRE   = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  csr_unit_if.slave                        bus,
  input  logic [NUM_FP_PORTS-1:0]          i_fp_valid,
  input  logic [5*NUM_FP_PORTS-1:0]        i_fp_flags,
  input  logic [$clog2(NUM_RETIRE+1)-1:0]  i_retire_cnt,
  output logic [2:0]                       o_frm
);

  logic [4:0]      fflags_q;
  logic [2:0]      frm_q;
  logic [4:0]      acc;
  logic [XLEN-1:0] rd;
  logic [XLEN-1:0] wdata;
  logic            mapped;
  logic            we;
  logic            we_ffl;
  logic            we_frm;
  logic            we_fcsr;
  logic            unused_ok;

`ifdef CSR_COUNTERS_EN
  logic [63:0] cyc_q;
  logic [63:0] ins_q;
  logic        cy_inh_q;
  logic        ir_inh_q;
  logic        we_inh;
  logic        we_clo;
  logic        we_chi;
  logic        we_ilo;
  logic        we_ihi;
`endif

  always_comb begin
    acc = '0;
    for (int p = 0; p < NUM_FP_PORTS; p++)
      if (i_fp_valid[p])
        acc = acc | i_fp_flags[5*p +: 5];
  end

  always_comb begin
    rd     = '0;
    mapped = 1'b1;
    unique case (bus.csr_addr)
      12'h001: rd = XLEN'(fflags_q);
      12'h002: rd = XLEN'(frm_q);
      12'h003: rd = XLEN'({frm_q, fflags_q});
`ifdef CSR_COUNTERS_EN
      12'h320: rd = XLEN'({ir_inh_q, 1'b0, cy_inh_q});
      12'hB00, 12'hC00: rd = cyc_q[XLEN-1:0];
      12'hB02, 12'hC02: rd = ins_q[XLEN-1:0];
      12'hB80, 12'hC80:
        if (XLEN == 32) rd = XLEN'(cyc_q[63:32]);
        else mapped = 1'b0;
      12'hB82, 12'hC82:
        if (XLEN == 32) rd = XLEN'(ins_q[63:32]);
        else mapped = 1'b0;
`endif
      default: mapped = 1'b0;
    endcase
  end

  // 0xCxx are the read-only user counter aliases
  assign bus.rd_data = rd;
  assign bus.illegal = ~mapped |
    (bus.csr_write & (bus.csr_addr[11:8] == 4'hC));

  always_comb begin
    unique case (bus.csr_op)
      2'b01:   wdata = rd | bus.wr_data;
      2'b10:   wdata = rd & ~bus.wr_data;
      default: wdata = bus.wr_data;
    endcase
  end

  assign we      = bus.csr_write & ~bus.illegal;
  assign we_ffl  = we & (bus.csr_addr == 12'h001);
  assign we_frm  = we & (bus.csr_addr == 12'h002);
  assign we_fcsr = we & (bus.csr_addr == 12'h003);
  assign o_frm   = frm_q;

  // Flags are sticky: written (or held) value OR this cycle's reports
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fflags_q <= '0;
      frm_q    <= '0;
    end else begin
      fflags_q <= ((we_ffl | we_fcsr) ? wdata[4:0] : fflags_q) | acc;
      if (we_frm)
        frm_q <= wdata[2:0];
      else if (we_fcsr)
        frm_q <= wdata[7:5];
    end
  end

`ifdef CSR_COUNTERS_EN
  assign we_inh = we & (bus.csr_addr == 12'h320);
  assign we_clo = we & (bus.csr_addr == 12'hB00);
  assign we_chi = we & (bus.csr_addr == 12'hB80);
  assign we_ilo = we & (bus.csr_addr == 12'hB02);
  assign we_ihi = we & (bus.csr_addr == 12'hB82);

  // A half-write freezes the other half for that cycle (no carry)
  function automatic logic [63:0] cnt_next(
    input logic [63:0]     cur,
    input logic [63:0]     inc,
    input logic            wlo,
    input logic            whi,
    input logic [XLEN-1:0] wd
  );
    logic [63:0] n;
    n = cur + inc;
    if (wlo)
      n = (XLEN == 64) ? 64'(wd) : {cur[63:32], wd[31:0]};
    else if (whi)
      n = {wd[31:0], cur[31:0]};
    return n;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_q    <= '0;
      ins_q    <= '0;
      cy_inh_q <= 1'b0;
      ir_inh_q <= 1'b0;
    end else begin
      cyc_q <= cnt_next(cyc_q, {63'd0, ~cy_inh_q},
                        we_clo, we_chi, wdata);
      ins_q <= cnt_next(ins_q,
                        ir_inh_q ? 64'd0 : 64'(i_retire_cnt),
                        we_ilo, we_ihi, wdata);
      if (we_inh) begin
        cy_inh_q <= wdata[0];
        ir_inh_q <= wdata[2];
      end
    end
  end
`endif

  assign unused_ok = ^{i_retire_cnt, wdata};

endmodule
